vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per pixel, legal 1..16.
REQ-002 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-004 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-005 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-006 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-007 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-008 SHALL have parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-009 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-010 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-011 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-012 SHALL have port pixel_x, output, 10 bits: current horizontal count, for downstream pixel logic.
REQ-013 SHALL have port pixel_y, output, 10 bits: current vertical count.
REQ-014 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-015 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-016 SHALL have port blank, output, 1 bit: high outside the visible area.
REQ-017 SHALL have port frame_start, output, 1 bit: one-clk pulse at start of pixel (0,0).

Function
REQ-018 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); both SHALL be at most 1024.
REQ-019 SHALL run a divider counting 0..CLK_DIV-1 and wrapping; pix_tick SHALL be true when the divider equals CLK_DIV-1; CLK_DIV=1 gives pix_tick every cycle.
REQ-020 SHALL increment the horizontal count on pix_tick and wrap from H_TOTAL-1 to 0.
REQ-021 SHALL increment the vertical count only on the pix_tick that wraps the horizontal count, and wrap from V_TOTAL-1 to 0.
REQ-022 SHALL drive pixel_x and pixel_y as the registered horizontal and vertical counts, covering the full range including blanking, with no clamping.
REQ-023 SHALL register hsync, vsync, blank and frame_start on the same edge as the counts, so all outputs describe the same pixel in every cycle (zero relative skew).
REQ-024 SHALL drive hsync low only when H_ACTIVE+H_FP <= pixel_x <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
REQ-025 SHALL drive vsync low only when V_ACTIVE+V_FP <= pixel_y <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), across the whole of each such line.
REQ-026 SHALL drive blank high when pixel_x >= H_ACTIVE or pixel_y >= V_ACTIVE.
REQ-027 SHALL pulse frame_start high for exactly one clk cycle: the first cycle in which (pixel_x,pixel_y) = (0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1).
REQ-028 SHALL hold every output constant between pix_ticks, except that frame_start falls after one cycle.
REQ-029 SHALL have no input handshake; downstream logic samples the outputs every clk.

Reset
REQ-030 SHALL, while rst is low and without waiting for a clock edge, force: divider=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, blank=0, frame_start=0.
REQ-031 SHALL NOT assert frame_start for the (0,0) presented by reset; the first pulse is at the first frame wrap.
REQ-032 SHALL, after rst deasserts, produce the first pixel_x increment on the CLK_DIV-th rising clk edge.
REQ-033 SHALL make a reset asserted mid-frame abort the frame immediately, with no partial sync pulse held afterwards.

Verification
REQ-034 SHALL verify: rst low with clk running, then rst low asynchronously at pixel_x=300 -> all outputs take reset values before the next clk edge.
REQ-035 SHALL verify, at CLK_DIV=2: pixel_x advances every 2 clk; pixel_x 639->640 sets blank=1; 799->0 increments pixel_y.
REQ-036 SHALL verify: hsync falls at pixel_x=656 and rises at 752 (96 ticks low); line period is 800 ticks.
REQ-037 SHALL verify: vsync is low for pixel_y 490..491 (1600 ticks); frame_start pulses are 840000 clk apart at CLK_DIV=2.
REQ-038 SHALL verify: at (799,524) the next tick gives (0,0), blank=0, and frame_start=1 for exactly one clk; no pulse occurs after reset release.
REQ-039 SHALL verify, at CLK_DIV=1: pixel_x advances every clk and the frame is 420000 clk long.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: a pixel-rate divider drives horizontal/vertical counters,
// and every output is registered together so all of them describe the same pixel.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // No handshake: every output is valid in every clk and is sampled unconditionally.

  logic [DIV_W-1:0] div;
  logic             pix_tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [9:0]       x_next;
  logic [9:0]       y_next;

  assign pix_tick = (div == DIV_LAST);
  assign h_wrap   = (pixel_x == H_LAST);
  assign v_wrap   = (pixel_y == V_LAST);

  always_comb begin
    x_next = pixel_x + 10'd1;
    y_next = pixel_y;
    if (h_wrap) begin
      x_next = '0;
      y_next = v_wrap ? '0 : pixel_y + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else begin
      div <= pix_tick ? '0 : div + DIV_W'(1);
    end
  end

  // Sync/blank are decoded from the next counts so they land on the same edge as the counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        pixel_x     <= x_next;
        pixel_y     <= y_next;
        hsync       <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
        vsync       <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
        blank       <= (x_next >= H_VIS) || (y_next >= V_VIS);
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (CLK_DIV=2 and CLK_DIV=1) with full-width
// lines and a short frame height, checked cycle by cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE2    = H_TOTAL * 2;
  localparam int FRAME2   = H_TOTAL * V_TOTAL * 2;
  localparam int FRAME1   = H_TOTAL * V_TOTAL;

  localparam logic [23:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] px2, py2, px1, py1;
  logic       hs2, vs2, bl2, fs2;
  logic       hs1, vs1, bl1, fs1;
  logic [23:0] obs2, obs1;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  assign obs2 = {px2, py2, hs2, vs2, bl2, fs2};
  assign obs1 = {px1, py1, hs1, vs1, bl1, fs1};

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut2 (
    .clk(clk), .rst(rst), .pixel_x(px2), .pixel_y(py2),
    .hsync(hs2), .vsync(vs2), .blank(bl2), .frame_start(fs2)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut1 (
    .clk(clk), .rst(rst), .pixel_x(px1), .pixel_y(py1),
    .hsync(hs1), .vsync(vs1), .blank(bl1), .frame_start(fs1)
  );

  // Clock and a count of rising edges since reset release.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  // Raster model: after kk edges the pixel index is kk/d; everything follows from x,y.
  function automatic logic [23:0] expect_out(int kk, int d);
    int p, x, y;
    logic hs, vs, bl, fs;
    p  = kk / d;
    x  = p % H_TOTAL;
    y  = (p / H_TOTAL) % V_TOTAL;
    hs = !((x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC));
    vs = !((y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC));
    bl = (x >= H_ACTIVE) || (y >= V_ACTIVE);
    fs = (p > 0) && (p % (H_TOTAL * V_TOTAL) == 0) && (kk % d == 0);
    return {10'(x), 10'(y), hs, vs, bl, fs};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    total += 2;
    if (obs2 !== RST_VEC) begin
      bad++; $display("FAIL reset_hold_div2 got=%h want=%h", obs2, RST_VEC);
    end
    if (obs1 !== RST_VEC) begin
      bad++; $display("FAIL reset_hold_div1 got=%h want=%h", obs1, RST_VEC);
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (px2 == 10'd300) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL reach_x300 got=%0d want=300", px2);
    end
    #2 rst = 1'b0;
    #1;
    total += 2;
    if (obs2 !== RST_VEC) begin
      bad++; $display("FAIL async_reset_div2 got=%h want=%h", obs2, RST_VEC);
    end
    if (obs1 !== RST_VEC) begin
      bad++; $display("FAIL async_reset_div1 got=%h want=%h", obs1, RST_VEC);
    end
    @(negedge clk);
  endtask

  task automatic test_random_reset();
    logic [23:0] e2, e1;
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(50, 3000);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < n && bad <= 20; c++) begin
        @(negedge clk);
        e2 = expect_out(k, 2);
        e1 = expect_out(k, 1);
        total += 2;
        if (obs2 !== e2) begin
          bad++; $display("FAIL run_div2 k=%0d got=%h want=%h", k, obs2, e2);
        end
        if (obs1 !== e1) begin
          bad++; $display("FAIL run_div1 k=%0d got=%h want=%h", k, obs1, e1);
        end
      end
      #($urandom_range(1, 3)) rst = 1'b0;
      #1;
      total += 2;
      if (obs2 !== RST_VEC) begin
        bad++; $display("FAIL midframe_reset_div2 got=%h want=%h", obs2, RST_VEC);
      end
      if (obs1 !== RST_VEC) begin
        bad++; $display("FAIL midframe_reset_div1 got=%h want=%h", obs1, RST_VEC);
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
      total++;
      if (obs2 !== RST_VEC) begin
        bad++; $display("FAIL reset_held_div2 got=%h want=%h", obs2, RST_VEC);
      end
    end
  endtask

  task automatic test_frames();
    logic [23:0] e2, e1;
    logic       p_hs, p_vs;
    logic [9:0] p_px, p_py;
    int hs_fall = -1, vs_fall = -1, fs2_last = -1, fs1_last = -1;
    int fs2_cnt = 0, fs1_cnt = 0;
    @(negedge clk);
    rst  = 1'b1;
    p_hs = 1'b1; p_vs = 1'b1; p_px = '0; p_py = '0;
    for (int c = 0; c < 2 * FRAME2 + 100 && bad <= 20; c++) begin
      @(negedge clk);
      e2 = expect_out(k, 2);
      e1 = expect_out(k, 1);
      total += 2;
      if (obs2 !== e2) begin
        bad++; $display("FAIL frame_div2 k=%0d got=%h want=%h", k, obs2, e2);
      end
      if (obs1 !== e1) begin
        bad++; $display("FAIL frame_div1 k=%0d got=%h want=%h", k, obs1, e1);
      end
      if (p_px == 10'd639 && px2 == 10'd640) begin
        total++;
        if (bl2 !== 1'b1) begin bad++; $display("FAIL blank_at_640 got=%b want=1", bl2); end
      end
      if (p_px == 10'd799 && px2 == 10'd0) begin
        total++;
        if (py2 !== 10'((p_py + 1) % V_TOTAL)) begin
          bad++; $display("FAIL line_wrap_y got=%0d want=%0d", py2, (p_py + 1) % V_TOTAL);
        end
      end
      if (p_hs === 1'b1 && hs2 === 1'b0) begin
        total++;
        if (px2 !== 10'd656) begin bad++; $display("FAIL hsync_fall_x got=%0d want=656", px2); end
        if (hs_fall >= 0) begin
          total++;
          if (k - hs_fall !== LINE2) begin
            bad++; $display("FAIL line_period got=%0d want=%0d", k - hs_fall, LINE2);
          end
        end
        hs_fall = k;
      end
      if (p_hs === 1'b0 && hs2 === 1'b1 && hs_fall >= 0) begin
        total += 2;
        if (px2 !== 10'd752) begin bad++; $display("FAIL hsync_rise_x got=%0d want=752", px2); end
        if (k - hs_fall !== H_SYNC * 2) begin
          bad++; $display("FAIL hsync_width got=%0d want=%0d", k - hs_fall, H_SYNC * 2);
        end
      end
      if (p_vs === 1'b1 && vs2 === 1'b0) begin
        total++;
        if ({py2, px2} !== {10'(V_ACTIVE + V_FP), 10'd0}) begin
          bad++; $display("FAIL vsync_fall_pos got=(%0d,%0d) want=(0,%0d)", px2, py2, V_ACTIVE + V_FP);
        end
        vs_fall = k;
      end
      if (p_vs === 1'b0 && vs2 === 1'b1 && vs_fall >= 0) begin
        total++;
        if (k - vs_fall !== V_SYNC * LINE2) begin
          bad++; $display("FAIL vsync_width got=%0d want=%0d", k - vs_fall, V_SYNC * LINE2);
        end
      end
      if (fs2 === 1'b1) begin
        fs2_cnt++;
        total += 2;
        if ({px2, py2, bl2} !== 21'd0) begin
          bad++; $display("FAIL frame_start_pos got=(%0d,%0d,%b) want=(0,0,0)", px2, py2, bl2);
        end
        if (k - ((fs2_last >= 0) ? fs2_last : 0) !== FRAME2) begin
          bad++; $display("FAIL frame_period_div2 got=%0d want=%0d", k - fs2_last, FRAME2);
        end
        fs2_last = k;
      end
      if (fs1 === 1'b1) begin
        fs1_cnt++;
        total++;
        if (k - ((fs1_last >= 0) ? fs1_last : 0) !== FRAME1) begin
          bad++; $display("FAIL frame_period_div1 got=%0d want=%0d", k - fs1_last, FRAME1);
        end
        fs1_last = k;
      end
      p_hs = hs2; p_vs = vs2; p_px = px2; p_py = py2;
    end
    total += 2;
    if (fs2_cnt !== 2) begin bad++; $display("FAIL frame_count_div2 got=%0d want=2", fs2_cnt); end
    if (fs1_cnt !== 4) begin bad++; $display("FAIL frame_count_div1 got=%0d want=4", fs1_cnt); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_random_reset();
    test_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
